pgm_pkt_fifo_v2_0: RTL and testbench

Single-clock, parameterised packet FIFO: the next generation of the team's flex FIFO, with an inferred memory array.
- Adds frame-level commit/discard for the TSMAC datapath.
- Adds a selectable first-word-fall-through (FWFT) read port.
- Adds automatic drop of frames that overflow the FIFO.
The read side only sees fully committed frames. Sits between the MAC RX engine and the downstream frame consumer.

---
 rtl/pgm_pkt_fifo_v2_0.sv | 158 +++++++++++++++
 tb/tb_pgm_pkt_fifo_v2_0.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_pkt_fifo_v2_0.sv
// Single-clock packet FIFO: frame commit/discard, overflow auto-drop, selectable FWFT read port.
// Define PGM_FIFO_ERR_CNT_EN to build the saturating overflow/underflow attempt counters.
module pgm_pkt_fifo_v2_0 #(
    parameter int c_DATA_WIDTH       = 32,
    parameter int c_DEPTH_WIDTH      = 10,
    parameter int c_FWFT             = 1,
    parameter int c_ALMOST_FULL_NUM  = 1000,
    parameter int c_ALMOST_EMPTY_NUM = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [c_DATA_WIDTH-1:0]  wr_data,
    input  logic                     wr_eop,
    input  logic                     wr_drop,
    output logic                     wr_full,
    output logic                     almost_full,
    output logic [c_DEPTH_WIDTH:0]   wr_water_level,
    output logic                     ovf_drop,
    input  logic                     rd_en,
    output logic [c_DATA_WIDTH-1:0]  rd_data,
    output logic                     rd_empty,
    output logic                     almost_empty,
    output logic [c_DEPTH_WIDTH:0]   rd_water_level,
    output logic [15:0]              ovf_cnt,
    output logic [15:0]              udf_cnt
);
    localparam int          AW     = c_DEPTH_WIDTH;
    localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AF_LVL = c_ALMOST_FULL_NUM[AW:0];
    localparam logic [AW:0] AE_LVL = c_ALMOST_EMPTY_NUM[AW:0];

    typedef enum logic {ST_IDLE = 1'b0, ST_DISCARD = 1'b1} wr_st_e;

    logic [1:0]              rst_sync_q;
    logic                    rst_int_n;
    wr_st_e                  wr_st_q;
    logic [AW:0]             wr_ptr_q, cmt_ptr_q, rd_ptr_q;
    logic [c_DATA_WIDTH-1:0] rd_data_q;
    logic                    ovf_drop_q;
    logic                    pf_vld;
    logic                    rd_empty_w;
    logic [AW:0]             wr_lvl, rd_lvl;
    logic                    full_w, wr_acc, ovf_hit;
    logic [c_DATA_WIDTH-1:0] mem_q [0:(1<<AW)-1];

    // Reset asserts asynchronously everywhere, releases on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // The prefetched word still occupies capacity until it is popped.
    assign wr_lvl  = wr_ptr_q  - rd_ptr_q + {{AW{1'b0}}, pf_vld};
    assign rd_lvl  = cmt_ptr_q - rd_ptr_q + {{AW{1'b0}}, pf_vld};
    assign full_w  = (wr_lvl == DEPTH);
    assign wr_acc  = (wr_st_q == ST_IDLE) && wr_en && !wr_drop && !full_w;
    assign ovf_hit = (wr_st_q == ST_IDLE) && wr_en && !wr_drop && full_w;

    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_st_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            ovf_drop_q <= 1'b0;
        end else begin
            ovf_drop_q <= ovf_hit;
            if (wr_st_q == ST_IDLE) begin
                if (wr_drop) begin
                    wr_ptr_q <= cmt_ptr_q;
                end else if (ovf_hit) begin
                    wr_ptr_q <= cmt_ptr_q;
                    // An overflowing eop word already ends the frame: nothing left to swallow.
                    if (!wr_eop) wr_st_q <= ST_DISCARD;
                end else if (wr_acc) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    if (wr_eop) cmt_ptr_q <= wr_ptr_q + 1'b1;
                end
            end else begin
                if (wr_drop || (wr_en && wr_eop)) wr_st_q <= ST_IDLE;
            end
        end
    end

    generate
        if (c_FWFT != 0) begin : g_fwft
            logic pf_vld_q;
            logic avail, pop, load;

            assign avail = (cmt_ptr_q != rd_ptr_q);
            assign pop   = rd_en && pf_vld_q;
            assign load  = avail && (!pf_vld_q || rd_en);

            always_ff @(posedge clk or negedge rst_int_n) begin
                if (!rst_int_n) begin
                    pf_vld_q  <= 1'b0;
                    rd_ptr_q  <= '0;
                    rd_data_q <= '0;
                end else if (load) begin
                    rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_q  <= rd_ptr_q + 1'b1;
                    pf_vld_q  <= 1'b1;
                end else if (pop) begin
                    pf_vld_q  <= 1'b0;
                end
            end
            assign pf_vld     = pf_vld_q;
            assign rd_empty_w = !pf_vld_q;
        end else begin : g_std
            assign pf_vld     = 1'b0;
            assign rd_empty_w = (cmt_ptr_q == rd_ptr_q);

            always_ff @(posedge clk or negedge rst_int_n) begin
                if (!rst_int_n) begin
                    rd_ptr_q  <= '0;
                    rd_data_q <= '0;
                end else if (rd_en && !rd_empty_w) begin
                    rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
                    rd_ptr_q  <= rd_ptr_q + 1'b1;
                end
            end
        end
    endgenerate

`ifdef PGM_FIFO_ERR_CNT_EN
    logic [15:0] ovf_cnt_q, udf_cnt_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            if (wr_en && full_w && (ovf_cnt_q != 16'hFFFF))     ovf_cnt_q <= ovf_cnt_q + 16'd1;
            if (rd_en && rd_empty_w && (udf_cnt_q != 16'hFFFF)) udf_cnt_q <= udf_cnt_q + 16'd1;
        end
    end
    assign ovf_cnt = ovf_cnt_q;
    assign udf_cnt = udf_cnt_q;
`else
    assign ovf_cnt = '0;
    assign udf_cnt = '0;
`endif

    assign wr_full        = full_w;
    assign almost_full    = (wr_lvl >= AF_LVL);
    assign wr_water_level = wr_lvl;
    assign ovf_drop       = ovf_drop_q;
    assign rd_data        = rd_data_q;
    assign rd_empty       = rd_empty_w;
    assign almost_empty   = (rd_lvl <= AE_LVL);
    assign rd_water_level = rd_lvl;

endmodule

// File: tb/tb_pgm_pkt_fifo_v2_0.sv
// Bench for pgm_pkt_fifo_v2_0: frame-queue reference model plus a data scoreboard, FWFT and standard read instances.
module tb_pgm_pkt_fifo_v2_0;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sel;   // 0: FWFT instance active, 1: standard-read instance active
    logic       wr_en, wr_eop, wr_drop, rd_en;
    logic [7:0] wr_data;

    logic       a_wr_full, a_af, a_ovf, a_empty, a_ae;
    logic [4:0] a_wr_wl, a_rd_wl;
    logic [7:0] a_rd_data;
    logic [15:0] a_ovf_cnt, a_udf_cnt;
    logic       b_wr_full, b_af, b_ovf, b_empty, b_ae;
    logic [4:0] b_wr_wl, b_rd_wl;
    logic [7:0] b_rd_data;
    logic [15:0] b_ovf_cnt, b_udf_cnt;

    pgm_pkt_fifo_v2_0 #(.c_DATA_WIDTH(8), .c_DEPTH_WIDTH(4), .c_FWFT(1),
                        .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)) u_fwft (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en & ~sel), .wr_data(wr_data), .wr_eop(wr_eop & ~sel), .wr_drop(wr_drop & ~sel),
        .wr_full(a_wr_full), .almost_full(a_af), .wr_water_level(a_wr_wl), .ovf_drop(a_ovf),
        .rd_en(rd_en & ~sel), .rd_data(a_rd_data), .rd_empty(a_empty), .almost_empty(a_ae),
        .rd_water_level(a_rd_wl), .ovf_cnt(a_ovf_cnt), .udf_cnt(a_udf_cnt));

    pgm_pkt_fifo_v2_0 #(.c_DATA_WIDTH(8), .c_DEPTH_WIDTH(4), .c_FWFT(0),
                        .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)) u_std (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en & sel), .wr_data(wr_data), .wr_eop(wr_eop & sel), .wr_drop(wr_drop & sel),
        .wr_full(b_wr_full), .almost_full(b_af), .wr_water_level(b_wr_wl), .ovf_drop(b_ovf),
        .rd_en(rd_en & sel), .rd_data(b_rd_data), .rd_empty(b_empty), .almost_empty(b_ae),
        .rd_water_level(b_rd_wl), .ovf_cnt(b_ovf_cnt), .udf_cnt(b_udf_cnt));

    logic        o_wr_full, o_af, o_ovf, o_empty, o_ae;
    logic [4:0]  o_wr_wl, o_rd_wl;
    logic [7:0]  o_rd_data;
    logic [15:0] o_ovf_cnt, o_udf_cnt;
    assign o_wr_full = sel ? b_wr_full : a_wr_full;
    assign o_af      = sel ? b_af      : a_af;
    assign o_ovf     = sel ? b_ovf     : a_ovf;
    assign o_empty   = sel ? b_empty   : a_empty;
    assign o_ae      = sel ? b_ae      : a_ae;
    assign o_wr_wl   = sel ? b_wr_wl   : a_wr_wl;
    assign o_rd_wl   = sel ? b_rd_wl   : a_rd_wl;
    assign o_rd_data = sel ? b_rd_data : a_rd_data;
    assign o_ovf_cnt = sel ? b_ovf_cnt : a_ovf_cnt;
    assign o_udf_cnt = sel ? b_udf_cnt : a_udf_cnt;

    // Reference model: open frame words, committed-but-unread word count, discard flag.
    logic [7:0] pend[$];
    logic [7:0] sb_q[$];
    int  com_cnt, m_ovf_cnt, m_udf_cnt;
    bit  disc, exp_empty, exp_ovf, chk_b;
    int  n_tests, n_fail;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        pend.delete(); sb_q.delete();
        com_cnt = 0; m_ovf_cnt = 0; m_udf_cnt = 0;
        disc = 1'b0; exp_empty = 1'b1; exp_ovf = 1'b0;
    endtask

    // Called just after a rising edge; drives one cycle of inputs and checks state after the next edge.
    task automatic step(input bit we, input logic [7:0] wd, input bit eop, input bit drop, input bit re);
        int held, after_pop;
        bit full, pop;
        wr_en = we; wr_data = wd; wr_eop = eop; wr_drop = drop; rd_en = re;
        held = pend.size() + com_cnt;
        full = (held == 16);
        pop  = re && !exp_empty;
        if (re && exp_empty && m_udf_cnt < 65535) m_udf_cnt++;
        if (we && full && m_ovf_cnt < 65535)      m_ovf_cnt++;
        if (pop) com_cnt--;
        after_pop = com_cnt;
        exp_ovf = 1'b0;
        if (drop) begin
            pend.delete(); disc = 1'b0;
        end else if (disc) begin
            if (we && eop) disc = 1'b0;
        end else if (we) begin
            if (full) begin
                pend.delete(); exp_ovf = 1'b1; disc = !eop;
            end else begin
                pend.push_back(wd);
                if (eop) begin
                    foreach (pend[i]) sb_q.push_back(pend[i]);
                    com_cnt += pend.size();
                    pend.delete();
                end
            end
        end
        // FWFT shows a word one edge after commit; standard read sees it right away.
        exp_empty = (sel == 1'b0) ? (after_pop == 0) : (com_cnt == 0);
        @(posedge clk); #1;
        held = pend.size() + com_cnt;
        chk("wr_water_level", int'(o_wr_wl), held);
        chk("rd_water_level", int'(o_rd_wl), com_cnt);
        chk("rd_empty", int'(o_empty), int'(exp_empty));
        chk("wr_full", int'(o_wr_full), int'(held == 16));
        chk("almost_full", int'(o_af), int'(held >= 14));
        chk("almost_empty", int'(o_ae), int'(com_cnt <= 2));
        chk("ovf_drop", int'(o_ovf), int'(exp_ovf));
`ifdef PGM_FIFO_ERR_CNT_EN
        chk("ovf_cnt", int'(o_ovf_cnt), m_ovf_cnt);
        chk("udf_cnt", int'(o_udf_cnt), m_udf_cnt);
`else
        chk("ovf_cnt_tied", int'(o_ovf_cnt), 0);
        chk("udf_cnt_tied", int'(o_udf_cnt), 0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0; wr_eop = 1'b0; wr_drop = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        #2;
        chk("rst_rd_data", int'(o_rd_data), 0);
        chk("rst_rd_empty", int'(o_empty), 1);
        chk("rst_almost_empty", int'(o_ae), 1);
        chk("rst_wr_full", int'(o_wr_full), 0);
        chk("rst_almost_full", int'(o_af), 0);
        chk("rst_ovf_drop", int'(o_ovf), 0);
        chk("rst_wr_wl", int'(o_wr_wl), 0);
        chk("rst_rd_wl", int'(o_rd_wl), 0);
        chk("rst_ovf_cnt", int'(o_ovf_cnt), 0);
        chk("rst_udf_cnt", int'(o_udf_cnt), 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step(0, 8'h00, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && com_cnt > 0; i++) step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0);
        chk("drain_sb_empty", sb_q.size(), 0);
    endtask

    task automatic rand_phase(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            bit hi, we, re, eop, drop;
            hi   = ((c / 200) % 2) == 0;
            we   = $urandom_range(0, 99) < (hi ? 80 : 40);
            re   = $urandom_range(0, 99) < (hi ? 25 : 70);
            eop  = $urandom_range(0, 3) == 0;
            drop = $urandom_range(0, 49) == 0;
            step(we, 8'($urandom), eop, drop, re);
        end
        drain();
    endtask

    // Scoreboard monitor: pops an expected word whenever the DUT delivers one.
    task automatic compare_pop();
        if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL rd_unexpected: got word %0d expected no word at %0t", o_rd_data, $time);
        end else begin
            chk("rd_data", int'(o_rd_data), int'(sb_q.pop_front()));
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk_b = 1'b0;
            end else begin
                if (chk_b) compare_pop();
                chk_b = 1'b0;
                if (rd_en && !o_empty) begin
                    if (sel == 1'b0) compare_pop();
                    else             chk_b = 1'b1;
                end
            end
        end
    end

    initial begin
        int pulses;
        n_tests = 0; n_fail = 0; chk_b = 1'b0;
        sel = 1'b0; rst_n = 1'b1;
        wr_en = 1'b0; wr_eop = 1'b0; wr_drop = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        model_clear();
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // FWFT commit latency
        step(1, 8'h11, 0, 0, 0); step(1, 8'h22, 0, 0, 0); step(1, 8'h33, 1, 0, 0);
        chk("t1_empty_at_commit", int'(o_empty), 1);
        step(0, 8'h00, 0, 0, 0);
        chk("t1_visible", int'(o_empty), 0);
        chk("t1_head", int'(o_rd_data), 8'h11);
        chk("t1_rd_wl", int'(o_rd_wl), 3);
        repeat (3) step(0, 8'h00, 0, 0, 1);
        chk("t1_empty_after_pops", int'(o_empty), 1);

        // Explicit drop, colliding with a write+eop
        for (int i = 0; i < 5; i++) step(1, 8'(8'hA0 + i), 0, 0, 0);
        step(1, 8'hEE, 1, 1, 0);
        chk("t2_wr_wl", int'(o_wr_wl), 0);
        step(1, 8'h51, 0, 0, 0); step(1, 8'h52, 1, 0, 0);
        drain();

        // Overflow auto-drop
        for (int i = 0; i < 4; i++) step(1, 8'(8'h30 + i), i == 3, 0, 0);
        pulses = 0;
        for (int i = 0; i < 13; i++) begin
            step(1, 8'(8'h40 + i), i == 12, 0, 0);
            if (o_ovf) pulses++;
        end
        step(0, 8'h00, 0, 0, 0);
        if (o_ovf) pulses++;
        chk("t3_ovf_pulses", pulses, 1);
        chk("t3_wr_wl", int'(o_wr_wl), 4);
        step(1, 8'h61, 0, 0, 0); step(1, 8'h62, 1, 0, 0);
        drain();

        // Thresholds and write-at-full with a same-cycle read
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(8'h70 + i), 1, 0, 0);
            if (i == 13) chk("t4_af_at_14", int'(o_af), 1);
            if (i == 14) chk("t4_not_full_15", int'(o_wr_full), 0);
        end
        chk("t4_full_16", int'(o_wr_full), 1);
        step(1, 8'h99, 1, 0, 1);
        chk("t4_full_rejects", int'(o_wr_wl), 15);
        while (com_cnt > 3) step(0, 8'h00, 0, 0, 1);
        chk("t4_ae_at_3", int'(o_ae), 0);
        step(0, 8'h00, 0, 0, 1);
        chk("t4_ae_at_2", int'(o_ae), 1);
        drain();

        // Overflow without eop enters discard until the frame ends
        for (int i = 0; i < 17; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
        step(1, 8'hB1, 0, 0, 1); step(1, 8'hB2, 1, 0, 0);
        step(1, 8'hC1, 1, 0, 0);
        drain();

        // Streaming single-word frames across pointer wrap
        for (int i = 0; i < 100; i++) step(1, 8'(i), 1, 0, 1);
        drain();

        rand_phase(1500);

        // Mid-operation reset with 7 words held
        for (int i = 0; i < 7; i++) step(1, 8'(8'hD0 + i), i == 4, 0, 0);
        do_reset();

        // Standard read port
        sel = 1'b1;
        do_reset();
        step(1, 8'hC1, 0, 0, 0); step(1, 8'hC2, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("t6_rd_data_holds", int'(o_rd_data), 0);
        step(0, 8'h00, 0, 0, 1);
        chk("t6_rd_latency", int'(o_rd_data), 8'hC1);
        drain();
        for (int i = 0; i < 7; i++) step(1, 8'(8'hE0 + i), i == 6, 0, 0);
        do_reset();
        repeat (3) step(0, 8'h00, 0, 0, 1);
`ifdef PGM_FIFO_ERR_CNT_EN
        chk("t6_udf_cnt_3", int'(o_udf_cnt), 3);
`endif
        rand_phase(1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
